// File: rtl/washing_pkg.sv
// Shared types and default timing for the washing machine sensor front end.
package washing_pkg;

   // Default clock and debounce window; 10 ms at 50 MHz is 500000 cycles.
   localparam int unsigned CLK_HZ                  = 50000000;
   localparam int unsigned DEBOUNCE_MS             = 10;
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

   // Start button tracking: one pulse per press, re-armed only by a release.
   typedef enum logic [0:0] {
      BTN_IDLE    = 1'b0,
      BTN_PRESSED = 1'b1
   } btn_state_e;

   // Width of a counter that must be able to hold the value n itself.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a stable-count debouncer for one raw switch.
module input_debouncer
   import washing_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk50m,
   input  logic rst_n,
   input  logic din_async,
   output logic dout
);

   localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic [CNT_W-1:0] cnt_q;

   // Bring the asynchronous switch into the clk50m domain.
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= din_async;
         sync2_q <= sync1_q;
      end
   end

   // Toggle the level only after DEBOUNCE_CYCLES consecutive differing samples.
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= 1'b0;
         cnt_q   <= '0;
      end else if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_q <= ~level_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_q <= '0;
      end
   end

   assign dout = level_q;

endmodule

// File: rtl/washing_sensor_frontend.sv
// Conditions raw washing machine sensors into clean single-domain FSM inputs.
// Optional fill-timeout supervision is enabled by WASHING_FRONTEND_FILL_TIMEOUT_EN.
module washing_sensor_frontend
   import washing_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned WASH_CYCLES     = 50000000,
   parameter int unsigned SPIN_CYCLES     = 25000000,
   parameter int unsigned FILL_TIMEOUT    = 100000000
) (
   input  logic clk50m,
   input  logic rst_n,
   input  logic start_btn_raw,
   input  logic level_sw_raw,
   input  logic temp_sw_raw,
   input  logic motor_wash,
   input  logic motor_spin,
   input  logic valve,
   output logic start,
   output logic full,
   output logic hot,
   output logic clean,
   output logic dry,
   output logic fill_fault
);

   localparam int unsigned       WASH_W    = cnt_width(WASH_CYCLES);
   localparam logic [WASH_W-1:0] WASH_LAST = WASH_W'(WASH_CYCLES - 1);
   localparam logic [WASH_W-1:0] WASH_SAT  = WASH_W'(WASH_CYCLES);
   localparam int unsigned       SPIN_W    = cnt_width(SPIN_CYCLES);
   localparam logic [SPIN_W-1:0] SPIN_LAST = SPIN_W'(SPIN_CYCLES - 1);
   localparam logic [SPIN_W-1:0] SPIN_SAT  = SPIN_W'(SPIN_CYCLES);

   logic              btn_db;
   logic              full_db;
   logic              hot_db;
   btn_state_e        btn_state_q;
   btn_state_e        btn_state_d;
   logic              start_d;
   logic              start_q;
   logic [WASH_W-1:0] wash_cnt_q;
   logic [SPIN_W-1:0] spin_cnt_q;

   input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn_db (
      .clk50m   (clk50m),
      .rst_n    (rst_n),
      .din_async(start_btn_raw),
      .dout     (btn_db)
   );

   input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_level_db (
      .clk50m   (clk50m),
      .rst_n    (rst_n),
      .din_async(level_sw_raw),
      .dout     (full_db)
   );

   input_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_temp_db (
      .clk50m   (clk50m),
      .rst_n    (rst_n),
      .din_async(temp_sw_raw),
      .dout     (hot_db)
   );

   assign full = full_db;
   assign hot  = hot_db;

   // Button FSM: pulse on the IDLE->PRESSED transition, re-arm on debounced release.
   always_comb begin
      btn_state_d = btn_state_q;
      start_d     = 1'b0;
      unique case (btn_state_q)
         BTN_IDLE: begin
            if (btn_db) begin
               btn_state_d = BTN_PRESSED;
               start_d     = 1'b1;
            end
         end
         BTN_PRESSED: begin
            if (!btn_db) begin
               btn_state_d = BTN_IDLE;
            end
         end
      endcase
   end

   // Button state and registered start pulse.
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         btn_state_q <= BTN_IDLE;
         start_q     <= 1'b0;
      end else begin
         btn_state_q <= btn_state_d;
         start_q     <= start_d;
      end
   end

   assign start = start_q;

   // Wash timer: counts while motor_wash is high, saturating past the pulse point.
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         wash_cnt_q <= '0;
      end else if (!motor_wash) begin
         wash_cnt_q <= '0;
      end else if (wash_cnt_q != WASH_SAT) begin
         wash_cnt_q <= wash_cnt_q + WASH_W'(1);
      end
   end

   // Spin timer: same scheme as the wash timer, independent of it.
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         spin_cnt_q <= '0;
      end else if (!motor_spin) begin
         spin_cnt_q <= '0;
      end else if (spin_cnt_q != SPIN_SAT) begin
         spin_cnt_q <= spin_cnt_q + SPIN_W'(1);
      end
   end

   // Count 0 is the first motor-high cycle, so a count of N-1 marks the Nth cycle.
   assign clean = motor_wash & (wash_cnt_q == WASH_LAST);
   assign dry   = motor_spin & (spin_cnt_q == SPIN_LAST);

`ifdef WASHING_FRONTEND_FILL_TIMEOUT_EN
   localparam int unsigned       FILL_W    = cnt_width(FILL_TIMEOUT);
   localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_TIMEOUT - 1);

   logic [FILL_W-1:0] fill_cnt_q;
   logic              fault_q;
   logic              fill_run;
   logic              fill_hit;

   assign fill_run = valve & ~full_db;
   assign fill_hit = fill_run & (fill_cnt_q == FILL_LAST);

   // Fill counter: runs while filling without reaching the level switch.
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         fill_cnt_q <= '0;
      end else if (!fill_run) begin
         fill_cnt_q <= '0;
      end else if (fill_cnt_q != FILL_LAST) begin
         fill_cnt_q <= fill_cnt_q + FILL_W'(1);
      end
   end

   // Sticky fault flag, cleared only by reset.
   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else if (fill_hit) begin
         fault_q <= 1'b1;
      end
   end

   assign fill_fault = fault_q | fill_hit;
`else
   logic unused_fill;
   assign unused_fill = valve ^ (FILL_TIMEOUT == 32'd0);
   assign fill_fault  = 1'b0;
`endif

endmodule

// File: tb/tb_washing_sensor_frontend.sv
// Directed self-checking bench for washing_sensor_frontend with a pulse scoreboard.
module tb_washing_sensor_frontend;

   localparam int KStart = 0;
   localparam int KClean = 1;
   localparam int KDry   = 2;

   typedef struct {
      int kind;
      int cyc;
   } ev_t;

   logic clk50m;
   logic rst_n;
   logic start_btn_raw;
   logic level_sw_raw;
   logic temp_sw_raw;
   logic motor_wash;
   logic motor_spin;
   logic valve;
   logic start;
   logic full;
   logic hot;
   logic clean;
   logic dry;
   logic fill_fault;

   int  checks      = 0;
   int  errors      = 0;
   int  cyc         = 0;
   int  fill_on_cyc = -1;
   ev_t exp_q[$];

   washing_sensor_frontend #(
      .DEBOUNCE_CYCLES(4),
      .WASH_CYCLES    (20),
      .SPIN_CYCLES    (10),
      .FILL_TIMEOUT   (50)
   ) dut (
      .clk50m       (clk50m),
      .rst_n        (rst_n),
      .start_btn_raw(start_btn_raw),
      .level_sw_raw (level_sw_raw),
      .temp_sw_raw  (temp_sw_raw),
      .motor_wash   (motor_wash),
      .motor_spin   (motor_spin),
      .valve        (valve),
      .start        (start),
      .full         (full),
      .hot          (hot),
      .clean        (clean),
      .dry          (dry),
      .fill_fault   (fill_fault)
   );

   initial begin
      clk50m = 1'b0;
      forever #5 clk50m = ~clk50m;
   end

   task automatic check_bit(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic push(input int kind, input int at);
      ev_t e;
      e.kind = kind;
      e.cyc  = at;
      exp_q.push_back(e);
   endtask

   // An observed pulse must match the oldest outstanding expectation exactly.
   task automatic check_pulse(input logic obs, input int kind, input string name);
      ev_t e;
      if (obs === 1'b1) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_%s: observed pulse at cycle %0d expected none", name, cyc);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            assert (kind == e.kind && cyc == e.cyc) else begin
               errors++;
               $error("FAIL pulse_%s: observed kind=%0d cycle=%0d expected kind=%0d cycle=%0d",
                      name, kind, cyc, e.kind, e.cyc);
            end
         end
      end
   endtask

   task automatic drained(input string tag);
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL %s: observed %0d pending pulses expected 0 (next at cycle %0d)",
                tag, exp_q.size(), exp_q[0].cyc);
         exp_q.delete();
      end
   endtask

   // Advance n clocks, checking pulses and fill_fault mid-cycle in every window.
   task automatic cycles(input int n);
      logic exp_fill;
      for (int i = 0; i < n; i++) begin
         #2;
         check_pulse(start, KStart, "start");
         check_pulse(clean, KClean, "clean");
         check_pulse(dry, KDry, "dry");
         exp_fill = (fill_on_cyc >= 0) && (cyc >= fill_on_cyc);
         check_bit("fill_fault", fill_fault, exp_fill);
         @(posedge clk50m);
         #1;
         cyc++;
      end
   endtask

   initial begin
      int t;
      rst_n         = 1'b0;
      start_btn_raw = 1'b1;
      level_sw_raw  = 1'b1;
      temp_sw_raw   = 1'b1;
      motor_wash    = 1'b0;
      motor_spin    = 1'b0;
      valve         = 1'b0;
      repeat (3) @(posedge clk50m);
      #1;

      // Reset with raw inputs high: everything reads 0.
      check_bit("rst_start", start, 1'b0);
      check_bit("rst_full", full, 1'b0);
      check_bit("rst_hot", hot, 1'b0);
      check_bit("rst_clean", clean, 1'b0);
      check_bit("rst_dry", dry, 1'b0);
      check_bit("rst_fill_fault", fill_fault, 1'b0);

      // Release: levels rise after 6 clocks, held button pulses after 7.
      rst_n = 1'b1;
      t = cyc;
      push(KStart, t + 7);
      cycles(5);
      check_bit("full_before_6", full, 1'b0);
      check_bit("hot_before_6", hot, 1'b0);
      cycles(1);
      check_bit("full_at_6", full, 1'b1);
      check_bit("hot_at_6", hot, 1'b1);
      cycles(10);
      drained("after_reset_release");
      start_btn_raw = 1'b0;
      level_sw_raw  = 1'b0;
      temp_sw_raw   = 1'b0;
      cycles(10);
      check_bit("full_released", full, 1'b0);
      check_bit("hot_released", hot, 1'b0);

      // Bouncy press followed by a long hold: one pulse 7 clocks after stable.
      start_btn_raw = 1'b1;
      cycles(1);
      start_btn_raw = 1'b0;
      cycles(1);
      start_btn_raw = 1'b1;
      cycles(1);
      start_btn_raw = 1'b0;
      cycles(1);
      t = cyc;
      start_btn_raw = 1'b1;
      push(KStart, t + 7);
      cycles(40);
      drained("bouncy_press");
      start_btn_raw = 1'b0;
      cycles(10);
      t = cyc;
      start_btn_raw = 1'b1;
      push(KStart, t + 7);
      cycles(20);
      drained("second_press");
      start_btn_raw = 1'b0;
      cycles(10);

      // Glitch rejection on the level switch.
      level_sw_raw = 1'b1;
      cycles(3);
      level_sw_raw = 1'b0;
      cycles(10);
      check_bit("full_glitch", full, 1'b0);
      level_sw_raw = 1'b1;
      cycles(5);
      check_bit("full_long_before_6", full, 1'b0);
      cycles(1);
      check_bit("full_long_at_6", full, 1'b1);
      cycles(4);
      level_sw_raw = 1'b0;
      cycles(10);
      check_bit("full_long_fall", full, 1'b0);

      // Wash timer: single pulse on the 20th cycle, then saturated.
      t = cyc;
      motor_wash = 1'b1;
      push(KClean, t + 19);
      cycles(30);
      motor_wash = 1'b0;
      cycles(2);
      drained("wash_30");

      // Early drop restarts the wash timer.
      motor_wash = 1'b1;
      cycles(15);
      motor_wash = 1'b0;
      cycles(1);
      t = cyc;
      motor_wash = 1'b1;
      push(KClean, t + 19);
      cycles(25);
      motor_wash = 1'b0;
      cycles(2);
      drained("wash_restart");

      // Overlapping spin and wash run independently.
      t = cyc;
      motor_wash = 1'b1;
      motor_spin = 1'b1;
      push(KDry, t + 9);
      push(KClean, t + 19);
      cycles(30);
      motor_wash = 1'b0;
      motor_spin = 1'b0;
      cycles(2);
      drained("overlap");

      // Fill timeout: fault on the 50th cycle and sticky afterwards (feature build only).
      t = cyc;
      valve = 1'b1;
`ifdef WASHING_FRONTEND_FILL_TIMEOUT_EN
      fill_on_cyc = t + 49;
`endif
      cycles(60);
      valve = 1'b0;
      cycles(5);

      // Reset mid-wash drops the in-flight timer and clears the fault.
      motor_wash = 1'b1;
      cycles(10);
      rst_n       = 1'b0;
      fill_on_cyc = -1;
      cycles(2);
      check_bit("midrst_full", full, 1'b0);
      t = cyc;
      rst_n = 1'b1;
      push(KClean, t + 19);
      cycles(25);
      motor_wash = 1'b0;
      cycles(2);
      drained("mid_reset_wash");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
